// File: rtl/aes_mem_pkg.sv
// Shared constants for the AES mailbox sequencer: the RAM word map, the control-byte bit
// positions and the sequencer state encoding.
package aes_mem_pkg;

  localparam logic [1:0] CTRL   = 2'd0;
  localparam logic [1:0] KEY    = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  localparam int START   = 0;
  localparam int DONE    = 1;
  localparam int TIMEOUT = 2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RD_CTRL   = 4'd1,
    ST_CHK_CTRL  = 4'd2,
    ST_RD_KEY    = 4'd3,
    ST_LAT_KEY   = 4'd4,
    ST_RD_DATA   = 4'd5,
    ST_LAT_DATA  = 4'd6,
    ST_START     = 4'd7,
    ST_WAIT_DONE = 4'd8,
    ST_WR_RESULT = 4'd9,
    ST_WR_STATUS = 4'd10
  } state_e;

endpackage

// File: rtl/aes_mem_sequencer.sv
// Fabric-side owner of the AES mailbox RAM: polls the control word, runs one AES block per
// START request and posts the ciphertext, status byte and an irq pulse.
module aes_mem_sequencer
  import aes_mem_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [1:0]   mem_address,
  output logic         mem_chipselect,
  output logic         mem_write,
  output logic [15:0]  mem_byteenable,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  output logic         mem_clken,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data_in,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_data_out,
  output logic         busy,
  output logic         irq,
  output logic [15:0]  block_count
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [15:0]   poll_cnt_q;
  logic [15:0]   tmo_cnt_q;
  logic          timeout_q;
  logic [127:0]  result_q;
  logic [7:0]    status_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable && poll_cnt_q == POLL_LAST) state_d = ST_RD_CTRL;
      ST_RD_CTRL:   state_d = ST_CHK_CTRL;
      // mem_readdata holds word 0 here: it is the cycle after RD_CTRL drove the address.
      ST_CHK_CTRL:  state_d = mem_readdata[START] ? ST_RD_KEY : ST_IDLE;
      ST_RD_KEY:    state_d = ST_LAT_KEY;
      ST_LAT_KEY:   state_d = ST_RD_DATA;
      ST_RD_DATA:   state_d = ST_LAT_DATA;
      ST_LAT_DATA:  state_d = ST_START;
      ST_START:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (aes_done)                    state_d = ST_WR_RESULT;
        else if (tmo_cnt_q == TMO_LAST)  state_d = ST_WR_STATUS;
      end
      ST_WR_RESULT: state_d = ST_WR_STATUS;
      ST_WR_STATUS: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status_byte          = 8'h00;
    status_byte[DONE]    = !timeout_q;
    status_byte[TIMEOUT] = timeout_q;
  end

  always_comb begin
    mem_address    = CTRL;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 16'h0000;
    mem_writedata  = 128'd0;
    aes_start      = 1'b0;
    irq            = 1'b0;
    busy           = (state_q != ST_IDLE);
    case (state_q)
      ST_RD_CTRL: begin
        mem_address    = CTRL;
        mem_chipselect = 1'b1;
      end
      ST_RD_KEY: begin
        mem_address    = KEY;
        mem_chipselect = 1'b1;
      end
      ST_RD_DATA: begin
        mem_address    = DATA;
        mem_chipselect = 1'b1;
      end
      ST_START: aes_start = 1'b1;
      ST_WR_RESULT: begin
        mem_address    = RESULT;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = 16'hFFFF;
        mem_writedata  = result_q;
      end
      // Writing the whole status byte also clears the host's START bit.
      ST_WR_STATUS: begin
        mem_address    = CTRL;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = 16'h0001;
        mem_writedata  = {120'd0, status_byte};
        irq            = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_clken   <= 1'b0;
      poll_cnt_q  <= 16'd0;
      tmo_cnt_q   <= 16'd0;
      timeout_q   <= 1'b0;
      result_q    <= 128'd0;
      aes_key     <= 128'd0;
      aes_data_in <= 128'd0;
      block_count <= 16'd0;
    end else begin
      mem_clken <= 1'b1;
      // The poll counter only advances while idle and enabled; any other case parks it at 0.
      if (state_q == ST_IDLE && enable && poll_cnt_q != POLL_LAST)
        poll_cnt_q <= poll_cnt_q + 16'd1;
      else
        poll_cnt_q <= 16'd0;

      case (state_q)
        ST_LAT_KEY:  aes_key     <= mem_readdata;
        ST_LAT_DATA: aes_data_in <= mem_readdata;
        ST_START: begin
          tmo_cnt_q <= 16'd0;
          timeout_q <= 1'b0;
        end
        ST_WAIT_DONE: begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
          if (aes_done)                   result_q  <= aes_data_out;
          else if (tmo_cnt_q == TMO_LAST) timeout_q <= 1'b1;
        end
        ST_WR_STATUS: if (!timeout_q) block_count <= block_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
